// File: rtl/seg_pkg.sv
// Shared constants for the stopwatch display path: active-low segment
// patterns (bit0=a .. bit6=g), digit slot indices and the scan state type.
package seg_pkg;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [1:0] DIG_TENTHS = 2'd0;
    localparam logic [1:0] DIG_SONES  = 2'd1;
    localparam logic [1:0] DIG_STENS  = 2'd2;
    localparam logic [1:0] DIG_MIN    = 2'd3;

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_e;
endpackage

// File: rtl/seven_seg_scan_if.sv
// Digit inputs from the stopwatch core and the multiplexed display pins.
interface seven_seg_scan_if;
    logic [3:0] minutes;
    logic [2:0] secondTens;
    logic [3:0] secondOnes;
    logic [3:0] tenths;
    logic       lz_blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output minutes, secondTens, secondOnes, tenths, lz_blank,
                    input  an, seg, dp);
    modport slave  (input  minutes, secondTens, secondOnes, tenths, lz_blank,
                    output an, seg, dp);
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; values above
// max_val render as a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] val,
    input  logic [3:0] max_val,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        if (val <= max_val) begin
            case (val)
                4'd0: seg = SEG_0;
                4'd1: seg = SEG_1;
                4'd2: seg = SEG_2;
                4'd3: seg = SEG_3;
                4'd4: seg = SEG_4;
                4'd5: seg = SEG_5;
                4'd6: seg = SEG_6;
                4'd7: seg = SEG_7;
                4'd8: seg = SEG_8;
                4'd9: seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode scanner: per-frame snapshot, blanking gap before
// each digit, registered outputs.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic           clk,
    input  logic           reset,
    seven_seg_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BCYC = CW'(BLANK_CYC);
    localparam scan_state_e   RST_ST = (BLANK_CYC == 0) ? DRIVE : BLANK;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    scan_state_e   state_q, state_d;
    logic [3:0]    min_q, min_d, so_q, so_d, te_q, te_d;
    logic [2:0]    st_q, st_d;
    logic          lz_q, lz_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          wrap, capture, lz_off;
    logic [3:0]    dig_val, dig_max;
    logic [6:0]    dig_seg;

    bcd_to_seg u_dec (.val(dig_val), .max_val(dig_max), .seg(dig_seg));

    always_comb begin
        wrap    = (cnt_q == LAST);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_d == BCYC) state_d = DRIVE;
            DRIVE:   if (wrap && BLANK_CYC != 0) state_d = BLANK;
            default: state_d = RST_ST;
        endcase

        // The frame's first cycle decodes the values being captured, so a
        // zero-length blanking gap still shows the fresh snapshot on digit 0.
        capture = (cnt_q == '0) && (idx_q == 2'd0);
        min_d = capture ? bus.minutes    : min_q;
        st_d  = capture ? bus.secondTens : st_q;
        so_d  = capture ? bus.secondOnes : so_q;
        te_d  = capture ? bus.tenths     : te_q;
        lz_d  = capture ? bus.lz_blank   : lz_q;

        dig_val = te_d;
        dig_max = 4'd9;
        case (idx_q)
            DIG_SONES: dig_val = so_d;
            DIG_STENS: begin dig_val = {1'b0, st_d}; dig_max = 4'd5; end
            DIG_MIN:   dig_val = min_d;
            default:   dig_val = te_d;
        endcase

        lz_off = (idx_q == DIG_MIN) && lz_d && (min_d == 4'd0);
        an_d   = 4'b1111;
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        if (state_q == DRIVE && !lz_off) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = dig_seg;
            dp_d  = !((idx_q == DIG_SONES) || (idx_q == DIG_MIN));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= RST_ST;
            min_q   <= '0;
            st_q    <= '0;
            so_q    <= '0;
            te_q    <= '0;
            lz_q    <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            min_q   <= min_d;
            st_q    <= st_d;
            so_q    <= so_d;
            te_q    <= te_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench: one scanner with an 8-cycle slot and 2-cycle gap, one with
// no gap; every output is checked on every cycle of each frame.
module tb_seven_seg_scan;
    localparam logic [6:0] P0 = 7'b1000000, P2 = 7'b0100100, P3 = 7'b0110000,
                           P4 = 7'b0011001, P5 = 7'b0010010, P7 = 7'b1111000,
                           P9 = 7'b0010000, PD = 7'b0111111, POFF = 7'h7F;

    logic clk = 1'b0;
    logic rsta, rstb;
    logic [3:0] mi, so, te;
    logic [2:0] st;
    logic       lz;
    int n_chk = 0, n_pass = 0, fr = 0;

    seven_seg_scan_if ifa();
    seven_seg_scan_if ifb();

    assign ifa.minutes = mi; assign ifa.secondTens = st; assign ifa.secondOnes = so;
    assign ifa.tenths = te;  assign ifa.lz_blank = lz;
    assign ifb.minutes = mi; assign ifb.secondTens = st; assign ifb.secondOnes = so;
    assign ifb.tenths = te;  assign ifb.lz_blank = lz;

    seven_seg_scan #(.REFRESH_DIV(8), .BLANK_CYC(2)) u_a (.clk(clk), .reset(rsta), .bus(ifa));
    seven_seg_scan #(.REFRESH_DIV(8), .BLANK_CYC(0)) u_b (.clk(clk), .reset(rstb), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_rst(input bit sel, input string tag);
        chk({tag, "_an"},  sel ? 16'(ifb.an)  : 16'(ifa.an),  16'hF);
        chk({tag, "_seg"}, sel ? 16'(ifb.seg) : 16'(ifa.seg), 16'h7F);
        chk({tag, "_dp"},  sel ? 16'(ifb.dp)  : 16'(ifa.dp),  16'h1);
    endtask

    // Walks nedge clocks of one frame; at clock 10 (inside digit 1) the next
    // frame's inputs are applied, which must not leak into this frame.
    task automatic frame(input bit sel, input int bc,
                         input logic [6:0] s0, s1, s2, s3, input bit off3, input int nedge,
                         input logic [3:0] nm, input logic [2:0] nst,
                         input logic [3:0] nso, input logic [3:0] nte, input bit nlz);
        logic [6:0] sx [4];
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int idx, c;
        bit drv;
        sx[0] = s0; sx[1] = s1; sx[2] = s2; sx[3] = s3;
        fr++;
        for (int k = 1; k <= nedge; k++) begin
            @(posedge clk); #1;
            idx = (k - 1) / 8;
            c   = (k - 1) % 8;
            drv = (c >= bc) && !(idx == 3 && off3);
            ea  = drv ? ~(4'b0001 << idx) : 4'hF;
            es  = drv ? sx[idx] : POFF;
            ed  = drv ? !(idx == 1 || idx == 3) : 1'b1;
            chk($sformatf("f%0d_k%0d_an", fr, k),  sel ? 16'(ifb.an)  : 16'(ifa.an),  16'(ea));
            chk($sformatf("f%0d_k%0d_seg", fr, k), sel ? 16'(ifb.seg) : 16'(ifa.seg), 16'(es));
            chk($sformatf("f%0d_k%0d_dp", fr, k),  sel ? 16'(ifb.dp)  : 16'(ifa.dp),  16'(ed));
            if (k == 10) begin mi = nm; st = nst; so = nso; te = nte; lz = nlz; end
        end
    endtask

    initial begin
        rsta = 1'b1; rstb = 1'b1;
        mi = 4'd7; st = 3'd4; so = 4'd3; te = 4'd9; lz = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk_rst(1'b0, "rst_a");
        end
        rsta = 1'b0;
        // 7/4/3/9, then tenths 2 -> 5 mid-frame, then leading-zero cases, then dashes
        frame(0, 2, P9, P3, P4, P7, 0, 32, 4'd7, 3'd4, 4'd3, 4'd2, 1'b0);
        frame(0, 2, P2, P3, P4, P7, 0, 32, 4'd7, 3'd4, 4'd3, 4'd5, 1'b0);
        frame(0, 2, P5, P3, P4, P7, 0, 32, 4'd0, 3'd4, 4'd3, 4'd5, 1'b1);
        frame(0, 2, P5, P3, P4, P0, 1, 32, 4'd0, 3'd4, 4'd3, 4'd5, 1'b0);
        frame(0, 2, P5, P3, P4, P0, 0, 32, 4'd7, 3'd6, 4'd3, 4'hC, 1'b0);
        frame(0, 2, PD, P3, PD, P7, 0, 32, 4'd7, 3'd6, 4'd3, 4'hC, 1'b0);

        chk_rst(1'b1, "rst_b_held");
        rstb = 1'b0;
        frame(1, 0, PD, P3, PD, P7, 0, 32, 4'd7, 3'd6, 4'd3, 4'hC, 1'b0);
        frame(1, 0, PD, P3, PD, P7, 0, 20, 4'd7, 3'd6, 4'd3, 4'hC, 1'b0);
        rstb = 1'b1;
        @(posedge clk); #1;
        chk_rst(1'b1, "rst_b_mid");
        rstb = 1'b0;
        frame(1, 0, PD, P3, PD, P7, 0, 32, 4'd7, 3'd6, 4'd3, 4'hC, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
